// File: rtl/cpu_if_mc.sv
// Multi-channel CBUS register interface: version/scratch/LED registers, per-channel
// event counters with clear-on-read, and a masked sticky interrupt controller.
// Optional feature macro: CPU_IF_MC_CNT_SAT_EN (counters saturate instead of wrapping).
module cpu_if_mc #(
  parameter int                         CBUS_DATA_WIDTH = 16,
  parameter int                         CBUS_ADDR_WIDTH = 8,
  parameter logic [CBUS_DATA_WIDTH-1:0] FPGA_VERSION    = 16'h0402,
  parameter int                         NUM_CH          = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
  input  logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
  input  logic                       cbus_we,
  input  logic                       cbus_oe,
  input  logic [NUM_CH-1:0]          ch_event,
  input  logic [NUM_CH-1:0]          int_src,
  output logic [CBUS_DATA_WIDTH-1:0] cbus_rdata,
  output logic [7:0]                 led_ctrl,
  output logic                       irq
);

  localparam logic [CBUS_ADDR_WIDTH-1:0] ADDR_VERSION  = CBUS_ADDR_WIDTH'(8'h01);
  localparam logic [CBUS_ADDR_WIDTH-1:0] ADDR_INT_MASK = CBUS_ADDR_WIDTH'(8'h02);
  localparam logic [CBUS_ADDR_WIDTH-1:0] ADDR_LED_CTRL = CBUS_ADDR_WIDTH'(8'h03);
  localparam logic [CBUS_ADDR_WIDTH-1:0] ADDR_INT_STAT = CBUS_ADDR_WIDTH'(8'h04);
  localparam logic [CBUS_ADDR_WIDTH-1:0] ADDR_SCRATCH  = CBUS_ADDR_WIDTH'(8'h05);
  localparam logic [CBUS_ADDR_WIDTH-1:0] ADDR_CNT_CTRL = CBUS_ADDR_WIDTH'(8'h08);
  localparam int                         ADDR_CNT_BASE = 16;

  // Strobes are level signals with no ready/valid handshake: an access is taken
  // once, on the first cycle a strobe is seen high, however long it is held.
  logic                       we_d, oe_d;
  logic                       wr_stb, rd_stb;
  logic [NUM_CH-1:0]          int_mask, int_stat, int_src_d;
  logic [NUM_CH-1:0]          int_stat_nxt, w1c;
  logic [CBUS_DATA_WIDTH-1:0] scratch;
  logic                       cor_en;
  logic                       clr_all;
  logic [CBUS_DATA_WIDTH-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0]          cnt_sel, cor_hit;
  logic [CBUS_DATA_WIDTH-1:0] rd_val;

  assign wr_stb  = cbus_we & ~we_d;
  assign rd_stb  = cbus_oe & ~oe_d;
  assign clr_all = wr_stb && (cbus_addr == ADDR_CNT_CTRL) && cbus_wdata[1];
  assign cor_hit = (rd_stb && cor_en) ? cnt_sel : '0;
  assign w1c     = (wr_stb && (cbus_addr == ADDR_INT_STAT)) ? cbus_wdata[NUM_CH-1:0] : '0;
  // A rising source edge beats a simultaneous W1C of the same bit.
  assign int_stat_nxt = (int_stat & ~w1c) | (int_src & ~int_src_d);

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_sel[i] = (cbus_addr == CBUS_ADDR_WIDTH'(ADDR_CNT_BASE + i));
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel[i]) rd_val = cnt[i];
    end
    case (cbus_addr)
      ADDR_VERSION:  rd_val = FPGA_VERSION;
      ADDR_INT_MASK: rd_val[NUM_CH-1:0] = int_mask;
      ADDR_LED_CTRL: rd_val[7:0] = led_ctrl;
      ADDR_INT_STAT: rd_val[NUM_CH-1:0] = int_stat;
      ADDR_SCRATCH:  rd_val = ~scratch;
      ADDR_CNT_CTRL: rd_val[0] = cor_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_d       <= 1'b0;
      oe_d       <= 1'b0;
      int_src_d  <= '0;
      cbus_rdata <= '0;
      led_ctrl   <= '0;
      int_mask   <= '1;
      int_stat   <= '0;
      scratch    <= '0;
      cor_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      we_d      <= cbus_we;
      oe_d      <= cbus_oe;
      int_src_d <= int_src;
      if (rd_stb) cbus_rdata <= rd_val;
      if (wr_stb) begin
        case (cbus_addr)
          ADDR_INT_MASK: int_mask <= cbus_wdata[NUM_CH-1:0];
          ADDR_LED_CTRL: led_ctrl <= cbus_wdata[7:0];
          ADDR_SCRATCH:  scratch  <= cbus_wdata;
          ADDR_CNT_CTRL: cor_en   <= cbus_wdata[0];
          default: ;
        endcase
      end
      int_stat <= int_stat_nxt;
      irq      <= |(int_stat & ~int_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_all) begin
          cnt[i] <= '0;
        end else if (cor_hit[i]) begin
          // The event arriving with the clearing read starts the next count.
          cnt[i] <= ch_event[i] ? CBUS_DATA_WIDTH'(1) : '0;
        end else if (ch_event[i]) begin
`ifdef CPU_IF_MC_CNT_SAT_EN
          if (cnt[i] != '1) cnt[i] <= cnt[i] + CBUS_DATA_WIDTH'(1);
`else
          cnt[i] <= cnt[i] + CBUS_DATA_WIDTH'(1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_if_mc.sv
// Self-checking bench for cpu_if_mc: register table, multi-cycle corner sequences,
// then randomized transactions against a transaction-level register model.
module tb_cpu_if_mc;

  localparam int W   = 16;
  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    cbus_addr;
  logic [W-1:0]  cbus_wdata;
  logic          cbus_we, cbus_oe;
  logic [NCH-1:0] ch_event, int_src;
  logic [W-1:0]  cbus_rdata;
  logic [7:0]    led_ctrl;
  logic          irq;

  int n_vec = 0;
  int n_bad = 0;

  cpu_if_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cbus_addr  (cbus_addr),
    .cbus_wdata (cbus_wdata),
    .cbus_we    (cbus_we),
    .cbus_oe    (cbus_oe),
    .ch_event   (ch_event),
    .int_src    (int_src),
    .cbus_rdata (cbus_rdata),
    .led_ctrl   (led_ctrl),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cbus_we = 1'b0; cbus_oe = 1'b0;
    cbus_addr = '0; cbus_wdata = '0; ch_event = '0; int_src = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cbus_write(input logic [7:0] a, input logic [W-1:0] d);
    cbus_addr = a; cbus_wdata = d; cbus_we = 1'b1;
    tick();
    cbus_we = 1'b0;
    tick();
  endtask

  task automatic cbus_read(input logic [7:0] a, output logic [W-1:0] d);
    cbus_addr = a; cbus_oe = 1'b1;
    tick();
    d = cbus_rdata;
    cbus_oe = 1'b0;
    tick();
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [W-1:0] exp);
    logic [W-1:0] d;
    cbus_read(a, d);
    check(name, d, exp);
  endtask

  // ---------------- reference model ----------------
  int m_mask, m_led, m_stat, m_scr, m_cor, m_src;
  int m_cnt [NCH];

  function automatic void m_reset();
    m_mask = 'hF; m_led = 0; m_stat = 0; m_scr = 0; m_cor = 0; m_src = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endfunction

  function automatic int m_inc(input int v);
`ifdef CPU_IF_MC_CNT_SAT_EN
    return (v < 65535) ? v + 1 : 65535;
`else
    return (v + 1) % 65536;
`endif
  endfunction

  function automatic int m_read(input int a);
    int v;
    v = 0;
    case (a)
      1: v = 'h0402;
      2: v = m_mask;
      3: v = m_led;
      4: v = m_stat;
      5: v = (~m_scr) & 'hFFFF;
      8: v = m_cor;
      default: begin
        if (a >= 'h10 && a < 'h10 + NCH) begin
          v = m_cnt[a - 'h10];
          if (m_cor != 0) m_cnt[a - 'h10] = 0;
        end
      end
    endcase
    return v;
  endfunction

  function automatic void m_write(input int a, input int d);
    case (a)
      2: m_mask = d & 'hF;
      3: m_led  = d & 'hFF;
      4: m_stat = m_stat & ~(d & 'hF);
      5: m_scr  = d & 'hFFFF;
      8: begin
        m_cor = d & 1;
        if ((d & 2) != 0) for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic m_irq();
    return ((m_stat & ~m_mask & 'hF) != 0);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit           is_wr;
    logic [7:0]   addr;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit wr, input logic [7:0] a, input logic [W-1:0] d,
                                  input logic [W-1:0] e);
    vec_t v;
    v.is_wr = wr; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  logic [7:0] addr_tab [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08, 8'h10,
                                8'h11, 8'h12, 8'h13, 8'h14, 8'h7F, 8'h00, 8'h06};

  initial begin
    logic [W-1:0] d;
    int a, wd, op, ev, s;

    do_reset();

    // ---- table-driven register access ----
    add_vec(0, 8'h01, 0, 16'h0402);
    add_vec(0, 8'h02, 0, 16'h000F);
    add_vec(0, 8'h03, 0, 16'h0000);
    add_vec(0, 8'h04, 0, 16'h0000);
    add_vec(0, 8'h05, 0, 16'hFFFF);
    add_vec(0, 8'h08, 0, 16'h0000);
    add_vec(0, 8'h10, 0, 16'h0000);
    add_vec(0, 8'h13, 0, 16'h0000);
    add_vec(0, 8'h7F, 0, 16'h0000);
    add_vec(0, 8'h00, 0, 16'h0000);
    add_vec(1, 8'h03, 16'h1234, 0);
    add_vec(0, 8'h03, 0, 16'h0034);
    add_vec(1, 8'h02, 16'hFFF5, 0);
    add_vec(0, 8'h02, 0, 16'h0005);
    add_vec(1, 8'h01, 16'hBEEF, 0);
    add_vec(0, 8'h01, 0, 16'h0402);
    add_vec(1, 8'h08, 16'h0003, 0);
    add_vec(0, 8'h08, 0, 16'h0001);
    add_vec(1, 8'h08, 16'h0000, 0);
    add_vec(0, 8'h08, 0, 16'h0000);
    add_vec(1, 8'h10, 16'h00AA, 0);
    add_vec(0, 8'h10, 0, 16'h0000);
    add_vec(1, 8'h05, 16'h0000, 0);
    add_vec(0, 8'h05, 0, 16'hFFFF);

    check("reset_irq", W'(irq), 16'h0);
    check("reset_led", W'(led_ctrl), 16'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        cbus_write(vecs[i].addr, vecs[i].data);
      end else begin
        cbus_read(vecs[i].addr, d);
        check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), d, vecs[i].exp);
      end
    end
    check("tbl_led_out", W'(led_ctrl), 16'h0034);
    check("tbl_irq", W'(irq), 16'h0);

    // ---- held write strobe acts once ----
    do_reset();
    cbus_addr = 8'h05; cbus_wdata = 16'h1234; cbus_we = 1'b1;
    tick();
    cbus_wdata = 16'h5555;
    repeat (4) tick();
    cbus_we = 1'b0;
    tick();
    read_check("held_we_scratch", 8'h05, 16'hEDCB);
    read_check("unmapped_7f", 8'h7F, 16'h0000);

    // ---- read and write edges together: read sees pre-write value ----
    cbus_addr = 8'h05; cbus_wdata = 16'h0F0F; cbus_we = 1'b1; cbus_oe = 1'b1;
    tick();
    check("rw_same_cycle_rd", cbus_rdata, 16'hEDCB);
    cbus_we = 1'b0; cbus_oe = 1'b0;
    tick();
    read_check("rw_same_cycle_wr", 8'h05, 16'hF0F0);

    // ---- counters and clear-on-read ----
    repeat (3) begin
      ch_event = 4'b0100; tick();
      ch_event = 4'b0000; tick();
    end
    read_check("cnt2_three", 8'h12, 16'h0003);
    cbus_write(8'h08, 16'h0001);
    cbus_addr = 8'h12; cbus_oe = 1'b1; ch_event = 4'b0100;
    tick();
    check("cor_with_event_rd", cbus_rdata, 16'h0003);
    cbus_oe = 1'b0; ch_event = 4'b0000;
    tick();
    read_check("cor_after_event", 8'h12, 16'h0001);
    read_check("cor_cleared", 8'h12, 16'h0000);
    repeat (2) begin
      ch_event = 4'b0100; tick();
      ch_event = 4'b0000; tick();
    end
    cbus_addr = 8'h12; cbus_oe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("held_oe_hold%0d", k), cbus_rdata, 16'h0002);
    end
    cbus_oe = 1'b0;
    tick();
    read_check("held_oe_single_clear", 8'h12, 16'h0000);
    cbus_write(8'h08, 16'h0000);

    // ---- interrupts ----
    cbus_write(8'h02, 16'h000E);
    check("irq_idle", W'(irq), 16'h0);
    int_src = 4'b0001;
    tick();
    check("irq_after_1", W'(irq), 16'h0);
    tick();
    check("irq_after_2", W'(irq), 16'h1);
    read_check("int_stat_set", 8'h04, 16'h0001);
    int_src = 4'b0000;
    tick(); tick();
    cbus_addr = 8'h04; cbus_wdata = 16'h0001; cbus_we = 1'b1; int_src = 4'b0001;
    tick();
    cbus_we = 1'b0;
    tick();
    check("set_beats_w1c_irq", W'(irq), 16'h1);
    read_check("set_beats_w1c_stat", 8'h04, 16'h0001);
    cbus_addr = 8'h04; cbus_wdata = 16'h0001; cbus_we = 1'b1;
    tick();
    cbus_we = 1'b0;
    check("w1c_irq_1cyc", W'(irq), 16'h1);
    tick();
    check("w1c_irq_2cyc", W'(irq), 16'h0);
    int_src = 4'b0011;
    tick(); tick(); tick();
    check("masked_src_irq", W'(irq), 16'h0);
    read_check("masked_src_stat", 8'h04, 16'h0002);
    cbus_write(8'h02, 16'h0000);
    check("unmask_irq", W'(irq), 16'h1);
    cbus_write(8'h04, 16'h000F);
    check("w1c_all_irq", W'(irq), 16'h0);
    int_src = 4'b0000;

    // ---- counter overflow and CLR_ALL ----
    cbus_write(8'h08, 16'h0002);
    repeat (5) begin
      ch_event = 4'b0010; tick();
      ch_event = 4'b0000; tick();
    end
    ch_event = 4'b0001;
    repeat (65536) tick();
    ch_event = 4'b0000;
    tick();
`ifdef CPU_IF_MC_CNT_SAT_EN
    read_check("cnt0_overflow", 8'h10, 16'hFFFF);
`else
    read_check("cnt0_overflow", 8'h10, 16'h0000);
`endif
    read_check("cnt1_five", 8'h11, 16'h0005);
    cbus_addr = 8'h08; cbus_wdata = 16'h0002; cbus_we = 1'b1; ch_event = 4'b0011;
    tick();
    cbus_we = 1'b0; ch_event = 4'b0000;
    tick();
    for (int i = 0; i < NCH; i++) read_check($sformatf("clr_all_cnt%0d", i), 8'(8'h10 + i), 16'h0000);
    read_check("clr_all_selfclear", 8'h08, 16'h0000);

    // ---- reset during a held read ----
    cbus_write(8'h03, 16'h005A);
    cbus_addr = 8'h01; cbus_oe = 1'b1;
    tick();
    check("pre_reset_rd", cbus_rdata, 16'h0402);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rdata", cbus_rdata, 16'h0000);
    check("async_reset_led", W'(led_ctrl), 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_held_oe", cbus_rdata, 16'h0402);
    cbus_oe = 1'b0;
    tick();

    // ---- randomized transactions vs model ----
    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          a  = addr_tab[$urandom_range(0, 13)];
          wd = $urandom_range(0, 65535);
          cbus_write(8'(a), W'(wd));
          m_write(a, wd);
        end
        1: begin
          a = addr_tab[$urandom_range(0, 13)];
          cbus_read(8'(a), d);
          check($sformatf("rnd%0d_rd_%02h", n, a), d, W'(m_read(a)));
        end
        2: begin
          ev = $urandom_range(0, 15);
          ch_event = 4'(ev); tick();
          ch_event = 4'b0000; tick();
          for (int i = 0; i < NCH; i++) if (ev[i]) m_cnt[i] = m_inc(m_cnt[i]);
        end
        default: begin
          s = $urandom_range(0, 15);
          m_stat = m_stat | (s & ~m_src);
          m_src  = s;
          int_src = 4'(s);
          tick(); tick();
        end
      endcase
      check($sformatf("rnd%0d_irq", n), W'(irq), W'(m_irq()));
      check($sformatf("rnd%0d_led", n), W'(led_ctrl), W'(m_led));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
